sad_engine: RTL and testbench

Producer side of the 16-candidate SAD interface consumed by the minimum-search comparator.
- Accepts one 4x4 current block and one 7x7 reference search window over a valid/ready pixel stream.
- Computes the 16 candidate SADs, one per displacement (dx,dy) in 0..3.
- Presents the SADs on sum0..sum15 and pulses sums_valid, which drives the comparator's enable.

---
 rtl/sad_pkg.sv | 24 ++
 rtl/sad_absdiff_tree.sv | 40 ++++
 rtl/sad_engine.sv | 154 +++++++++++++++
 tb/tb_sad_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants and types for the 16-candidate SAD producer.
// Optional build macro used by sad_engine: SAD_ENGINE_PERF_CNT_EN.
package sad_pkg;

   localparam int PIX_W = 8;
   localparam int BLK   = 4;
   localparam int RANGE = 4;
   localparam int SUM_W = 12;
   localparam int WIN   = BLK + RANGE - 1;
   localparam int NCAND = RANGE * RANGE;
   localparam int NPIX  = BLK * BLK;
   localparam int NREF  = WIN * WIN;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_CUR = 3'd1,
      ST_LOAD_REF = 3'd2,
      ST_CALC     = 3'd3,
      ST_DONE     = 3'd4
   } sad_state_t;

   typedef logic [3:0] cand_idx_t;

endpackage

// File: rtl/sad_absdiff_tree.sv
// Combinational SAD of one 4x4 block against one selected 4x4 reference patch:
// 16 absolute differences reduced by a balanced 4-level adder tree.
module sad_absdiff_tree
   import sad_pkg::*;
(
   input  logic [PIX_W-1:0] cur_i [NPIX],
   input  logic [PIX_W-1:0] ref_i [NPIX],
   output logic [SUM_W-1:0] sad_o
);

   // Difference is taken one bit wider and signed so the magnitude never wraps.
   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      logic signed [PIX_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[PIX_W] ? PIX_W'(-d) : PIX_W'(d);
   endfunction

   logic [SUM_W-1:0] lvl0 [NPIX];
   logic [SUM_W-1:0] lvl1 [NPIX/2];
   logic [SUM_W-1:0] lvl2 [NPIX/4];
   logic [SUM_W-1:0] lvl3 [NPIX/8];

   always_comb begin
      for (int n = 0; n < NPIX; n++) begin
         lvl0[n] = SUM_W'(abs_diff(cur_i[n], ref_i[n]));
      end
      for (int n = 0; n < NPIX/2; n++) begin
         lvl1[n] = lvl0[2*n] + lvl0[2*n+1];
      end
      for (int n = 0; n < NPIX/4; n++) begin
         lvl2[n] = lvl1[2*n] + lvl1[2*n+1];
      end
      for (int n = 0; n < NPIX/8; n++) begin
         lvl3[n] = lvl2[2*n] + lvl2[2*n+1];
      end
      sad_o = lvl3[0] + lvl3[1];
   end

endmodule

// File: rtl/sad_engine.sv
// SAD producer: loads a 4x4 block and 7x7 window, emits 16 candidate SADs with a sums_valid pulse.
// Optional SAD_ENGINE_PERF_CNT_EN adds a 16-bit wrapping blk_count of completed blocks.
module sad_engine
   import sad_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_data,
   output logic             pix_ready,
   output logic             busy,
   output logic             sums_valid,
`ifdef SAD_ENGINE_PERF_CNT_EN
   output logic [15:0]      blk_count,
`endif
   output logic [SUM_W-1:0] sum0,
   output logic [SUM_W-1:0] sum1,
   output logic [SUM_W-1:0] sum2,
   output logic [SUM_W-1:0] sum3,
   output logic [SUM_W-1:0] sum4,
   output logic [SUM_W-1:0] sum5,
   output logic [SUM_W-1:0] sum6,
   output logic [SUM_W-1:0] sum7,
   output logic [SUM_W-1:0] sum8,
   output logic [SUM_W-1:0] sum9,
   output logic [SUM_W-1:0] sum10,
   output logic [SUM_W-1:0] sum11,
   output logic [SUM_W-1:0] sum12,
   output logic [SUM_W-1:0] sum13,
   output logic [SUM_W-1:0] sum14,
   output logic [SUM_W-1:0] sum15
);

   sad_state_t       state_q, state_d;
   logic [5:0]       beat_q, beat_d;
   cand_idx_t        cand_q, cand_d;
   logic [PIX_W-1:0] cur_q   [NPIX];
   logic [PIX_W-1:0] ref_q   [NREF];
   logic [PIX_W-1:0] win_sel [NPIX];
   logic [SUM_W-1:0] sum_q   [NCAND];
   logic [SUM_W-1:0] sad;
   logic             beat;

   assign pix_ready  = (state_q == ST_LOAD_CUR) || (state_q == ST_LOAD_REF);
   assign busy       = (state_q != ST_IDLE);
   assign sums_valid = (state_q == ST_DONE);
   assign beat       = pix_valid & pix_ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cand_d  = cand_q;
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            cand_d = '0;
            if (start) state_d = ST_LOAD_CUR;
         end
         ST_LOAD_CUR: begin
            if (beat) begin
               if (beat_q == 6'(NPIX - 1)) begin
                  beat_d  = '0;
                  state_d = ST_LOAD_REF;
               end else begin
                  beat_d = beat_q + 6'd1;
               end
            end
         end
         ST_LOAD_REF: begin
            if (beat) begin
               if (beat_q == 6'(NREF - 1)) begin
                  beat_d  = '0;
                  cand_d  = '0;
                  state_d = ST_CALC;
               end else begin
                  beat_d = beat_q + 6'd1;
               end
            end
         end
         ST_CALC: begin
            cand_d = cand_q + 4'd1;
            if (cand_q == cand_idx_t'(NCAND - 1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel buffers carry no reset; contents are only meaningful after a full load.
   always_ff @(posedge clk) begin
      if (state_q == ST_LOAD_CUR && beat) cur_q[beat_q[3:0]] <= pix_data;
      if (state_q == ST_LOAD_REF && beat) ref_q[beat_q]      <= pix_data;
   end

   // Candidate k selects the 4x4 patch at row offset k>>2, column offset k&3.
   always_comb begin
      for (int i = 0; i < BLK; i++) begin
         for (int j = 0; j < BLK; j++) begin
            win_sel[i*BLK + j] =
               ref_q[6'((i + int'(cand_q[3:2])) * WIN + j + int'(cand_q[1:0]))];
         end
      end
   end

   sad_absdiff_tree u_tree (
      .cur_i (cur_q),
      .ref_i (win_sel),
      .sad_o (sad)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         cand_q  <= '0;
         for (int n = 0; n < NCAND; n++) sum_q[n] <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cand_q  <= cand_d;
         if (state_q == ST_CALC) sum_q[cand_q] <= sad;
      end
   end

`ifdef SAD_ENGINE_PERF_CNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)          blk_cnt_q <= '0;
      else if (sums_valid) blk_cnt_q <= blk_cnt_q + 16'd1;
   end

   assign blk_count = blk_cnt_q;
`endif

   assign sum0  = sum_q[0];
   assign sum1  = sum_q[1];
   assign sum2  = sum_q[2];
   assign sum3  = sum_q[3];
   assign sum4  = sum_q[4];
   assign sum5  = sum_q[5];
   assign sum6  = sum_q[6];
   assign sum7  = sum_q[7];
   assign sum8  = sum_q[8];
   assign sum9  = sum_q[9];
   assign sum10 = sum_q[10];
   assign sum11 = sum_q[11];
   assign sum12 = sum_q[12];
   assign sum13 = sum_q[13];
   assign sum14 = sum_q[14];
   assign sum15 = sum_q[15];

endmodule

// File: tb/tb_sad_engine.sv
// Scoreboard bench for sad_engine: stimulus pushes expected sums and due cycle,
// a negedge monitor pops and compares on every sums_valid pulse.
`timescale 1ns/1ps
module tb_sad_engine;
   import sad_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             pix_valid = 1'b0;
   logic [PIX_W-1:0] pix_data = '0;
   logic             pix_ready, busy, sums_valid;
   logic [SUM_W-1:0] sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7;
   logic [SUM_W-1:0] sum8, sum9, sum10, sum11, sum12, sum13, sum14, sum15;
   logic [SUM_W-1:0] s [NCAND];
`ifdef SAD_ENGINE_PERF_CNT_EN
   logic [15:0]      blk_count;
`endif

   always #5 clk = ~clk;

   sad_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .sums_valid (sums_valid),
`ifdef SAD_ENGINE_PERF_CNT_EN
      .blk_count  (blk_count),
`endif
      .sum0 (sum0),   .sum1 (sum1),   .sum2 (sum2),   .sum3 (sum3),
      .sum4 (sum4),   .sum5 (sum5),   .sum6 (sum6),   .sum7 (sum7),
      .sum8 (sum8),   .sum9 (sum9),   .sum10(sum10),  .sum11(sum11),
      .sum12(sum12),  .sum13(sum13),  .sum14(sum14),  .sum15(sum15)
   );

   assign s[0]  = sum0;   assign s[1]  = sum1;   assign s[2]  = sum2;   assign s[3]  = sum3;
   assign s[4]  = sum4;   assign s[5]  = sum5;   assign s[6]  = sum6;   assign s[7]  = sum7;
   assign s[8]  = sum8;   assign s[9]  = sum9;   assign s[10] = sum10;  assign s[11] = sum11;
   assign s[12] = sum12;  assign s[13] = sum13;  assign s[14] = sum14;  assign s[15] = sum15;

   typedef struct packed {
      logic [NCAND-1:0][SUM_W-1:0] sums;
      logic [31:0]                 due;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        nxt;
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          pulses = 0;
   int unsigned edges  = 0;
   int          cur_m [NPIX];
   int          ref_m [NREF];

   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int model_sad(input int k);
      int dy, dx, acc, d;
      dy  = k / RANGE;
      dx  = k % RANGE;
      acc = 0;
      for (int i = 0; i < BLK; i++) begin
         for (int j = 0; j < BLK; j++) begin
            d = cur_m[i*BLK + j] - ref_m[(i + dy)*WIN + j + dx];
            acc += (d < 0) ? -d : d;
         end
      end
      return acc;
   endfunction

   task automatic fill_uniform(input int c, input int r);
      for (int n = 0; n < NPIX; n++) cur_m[n] = c;
      for (int n = 0; n < NREF; n++) ref_m[n] = r;
   endtask

   task automatic fill_unique();
      for (int n = 0; n < NPIX; n++) cur_m[n] = n + 1;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            if (r >= 2 && r <= 5 && c >= 1 && c <= 4) ref_m[r*WIN + c] = cur_m[(r-2)*BLK + (c-1)];
            else                                      ref_m[r*WIN + c] = 200;
         end
      end
   endtask

   task automatic fill_mixed();
      for (int n = 0; n < NPIX; n++) cur_m[n] = (n * 11 + 5) % 256;
      for (int n = 0; n < NREF; n++) ref_m[n] = (n * 37) % 256;
   endtask

   task automatic exp_const(input int v);
      for (int k = 0; k < NCAND; k++) nxt.sums[k] = SUM_W'(v);
   endtask

   task automatic exp_model();
      for (int k = 0; k < NCAND; k++) nxt.sums[k] = SUM_W'(model_sad(k));
   endtask

   // One block: start in cycle 0, beats from cycle 1; alt inserts a bubble every other cycle.
   task automatic run_block(input int lat, input bit alt, input bit poke_ref,
                            input bit poke_done, input bit abort);
      int idx, guard;
      bit rdy, ph;
      idx = 0; guard = 0; ph = 1'b0;
      @(negedge clk);
      start = 1'b1;
      if (!abort) begin
         nxt.due = 32'(edges + lat);
         exp_q.push_back(nxt);
      end
      @(negedge clk);
      start = 1'b0;
      while (idx < NPIX + NREF && guard < 400) begin
         guard++;
         if (alt && ph) begin
            pix_valid = 1'b0;
            pix_data  = 8'hEE;
         end else begin
            pix_valid = 1'b1;
            pix_data  = PIX_W'(idx < NPIX ? cur_m[idx] : ref_m[idx - NPIX]);
         end
         start = poke_ref && (idx == NPIX + 20);
         rdy   = pix_ready;
         @(negedge clk);
         if (pix_valid && rdy) idx++;
         ph = ~ph;
      end
      pix_valid = 1'b0;
      start     = 1'b0;
      check("beats_loaded", idx, NPIX + NREF);
      if (abort) begin
         repeat (5) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         check("abort_busy", busy, 0);
         check("abort_ready", pix_ready, 0);
         check("abort_valid", sums_valid, 0);
         for (int k = 0; k < NCAND; k++) check($sformatf("abort_sum%0d", k), int'(s[k]), 0);
         rst_n = 1'b1;
      end else begin
         guard = 0;
         while (!sums_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         check("sums_valid_seen", sums_valid, 1);
         start = poke_done;
         @(negedge clk);
         start = 1'b0;
         check("busy_after_done", busy, 0);
         check("valid_one_cycle", sums_valid, 0);
         @(negedge clk);
         check("idle_after_done", busy, 0);
      end
   endtask

   always @(negedge clk) begin
      if (sums_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sums_valid: got pulse at edge %0d, expected none", edges);
         end else begin
            mon_e = exp_q.pop_front();
            check("sums_valid_cycle", int'(edges), int'(mon_e.due));
            for (int k = 0; k < NCAND; k++)
               check($sformatf("sum%0d", k), int'(s[k]), int'(mon_e.sums[k]));
         end
      end
   end

   initial begin
      int n_blocks;
      n_blocks = 0;
      repeat (3) @(negedge clk);
      check("rst_ready", pix_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", sums_valid, 0);
      check("rst_sum0", int'(s[0]), 0);
      check("rst_sum15", int'(s[15]), 0);
`ifdef SAD_ENGINE_PERF_CNT_EN
      check("rst_blk_count", int'(blk_count), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      fill_uniform(10, 10);
      exp_const(0);
      run_block(82, 1'b0, 1'b0, 1'b0, 1'b0);
      n_blocks++;

      fill_uniform(0, 255);
      exp_const(4080);
      run_block(82, 1'b0, 1'b0, 1'b0, 1'b0);
      n_blocks++;

      fill_unique();
      exp_model();
      run_block(82, 1'b0, 1'b0, 1'b0, 1'b0);
      n_blocks++;
      check("unique_sum9_zero", int'(s[9]), 0);
      for (int k = 0; k < NCAND; k++)
         if (k != 9) check($sformatf("unique_sum%0d_nonzero", k), int'(s[k] != '0), 1);
`ifdef SAD_ENGINE_PERF_CNT_EN
      check("blk_count_three", int'(blk_count), 3);
`endif

      run_block(146, 1'b1, 1'b0, 1'b0, 1'b0);
      n_blocks++;

      fill_mixed();
      exp_model();
      run_block(82, 1'b0, 1'b1, 1'b1, 1'b0);
      n_blocks++;

      fill_unique();
      run_block(82, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SAD_ENGINE_PERF_CNT_EN
      check("blk_count_after_reset", int'(blk_count), 0);
`endif

      fill_mixed();
      exp_model();
      run_block(82, 1'b0, 1'b0, 1'b0, 1'b0);
      n_blocks++;

      repeat (10) @(negedge clk);
      check("pending_expectations", exp_q.size(), 0);
      check("pulse_count", pulses, n_blocks);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
